// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle ARM-subset control unit: the main
// FSM state encoding, the ResultSrc mux codes and the ALU operand select
// codes used by the datapath.
// Ports: none (package).
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // Main controller states. The numeric values are visible on the debug
  // State port, so they are fixed here rather than left to the tools.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FPUEXEC  = 4'd10,
    FPUWAIT  = 4'd11,
    FPUWB    = 4'd12
  } state_t;

  // ResultSrc codes.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_FPU    = 2'b11;

  // ALUSrcA codes: register operand, program counter, registered ALU result.
  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  // ALUSrcB codes: register operand, extended immediate, constant four.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles the controller <-> datapath/FPU signals.
//   master : the controller (consumes Op/Funct/FPUDone, drives strobes)
//   slave  : the datapath side (drives Op/Funct/FPUDone, consumes strobes)
// Signals: Op[1:0], Funct[5:0], FPUDone, IRWrite, NextPC, RegW, MemW, Branch,
//          ALUOp, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0],
//          ResSrc, FPUStart, FPUErr, State[3:0].
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FPUDone;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ResSrc;
  logic       FPUStart;
  logic       FPUErr;
  logic [3:0] State;

  modport master (
    input  Op, Funct, FPUDone,
    output IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ResSrc, FPUStart, FPUErr, State
  );

  modport slave (
    output Op, Funct, FPUDone,
    input  IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ResSrc, FPUStart, FPUErr, State
  );
endinterface

// File: rtl/multicycle_ctrl_fpu_timer.sv
// ---------------------------------------------------------------------------
// fpu_timer
// Watchdog counter for the FPU wait state.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous, active-low reset
//   clr     in  clear the count (controller is not waiting on the FPU)
//   inc     in  advance the count by one
//   expired out count has reached FPU_TIMEOUT-1
// ---------------------------------------------------------------------------
module fpu_timer #(
  parameter int FPU_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(FPU_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(FPU_TIMEOUT - 1);

  logic [W-1:0] count;

  // Count saturates at the limit so it can never wrap back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multicycle ARM-subset core with a multi-cycle FPU.
// Sequences fetch/decode/memory/ALU/branch/FPU instructions and drives the
// datapath selects and raw write strobes (gated later by the condition
// logic). Runs the FPU start/done handshake with a watchdog timeout.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low reset; forces every output to 0
//   bus    master modport of multicycle_ctrl_if (Op/Funct/FPUDone in,
//          strobes, selects, FPUStart, sticky FPUErr and debug State out)
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int FPU_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  state_t state;
  state_t nextState;
  logic   timerExpired;
  logic   fpuTimeout;
  logic   fpuErr;

  // A done pulse on the limit cycle takes priority over the timeout.
  assign fpuTimeout = (state == FPUWAIT) && !bus.FPUDone && timerExpired;

  fpu_timer #(.FPU_TIMEOUT(FPU_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != FPUWAIT),
    .inc     ((state == FPUWAIT) && !bus.FPUDone),
    .expired (timerExpired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpuErr <= 1'b0;
    end else if (fpuTimeout) begin
      fpuErr <= 1'b1;
    end
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:    nextState = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   nextState = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   nextState = MEMADR;
          2'b10:   nextState = BRANCH;
          default: nextState = FPUEXEC;
        endcase
      end
      MEMADR:   nextState = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    nextState = MEMWB;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      FPUEXEC:  nextState = bus.FPUDone ? FPUWB : FPUWAIT;
      FPUWAIT: begin
        if (bus.FPUDone)       nextState = FPUWB;
        else if (timerExpired) nextState = FETCH;
        else                   nextState = FPUWAIT;
      end
      default:  nextState = FETCH;
    endcase
  end

  // Moore output decode. Reset overrides the decode combinationally so the
  // strobes drop the moment reset is asserted, not at the next edge.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = SRCA_REG;
    bus.ALUSrcB   = SRCB_REG;
    bus.ResultSrc = RES_ALUOUT;
    bus.ResSrc    = 1'b0;
    bus.FPUStart  = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
      end
      DECODE: begin
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
      end
      MEMADR:   bus.ALUSrcB = SRCB_IMM;
      MEMRD:    bus.AdrSrc  = 1'b1;
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegW      = 1'b1;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: bus.ALUOp = 1'b1;
      EXECUTEI: begin
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = 1'b1;
      end
      ALUWB:    bus.RegW = 1'b1;
      BRANCH: begin
        bus.ALUSrcA   = SRCA_ALUOUT;
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALU;
        bus.Branch    = 1'b1;
      end
      FPUEXEC: begin
        bus.FPUStart = 1'b1;
        bus.ResSrc   = 1'b1;
      end
      FPUWAIT:  bus.ResSrc = 1'b1;
      FPUWB: begin
        bus.ResultSrc = RES_FPU;
        bus.ResSrc    = 1'b1;
        bus.RegW      = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      bus.IRWrite   = 1'b0;
      bus.NextPC    = 1'b0;
      bus.RegW      = 1'b0;
      bus.MemW      = 1'b0;
      bus.Branch    = 1'b0;
      bus.ALUOp     = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      bus.ResSrc    = 1'b0;
      bus.FPUStart  = 1'b0;
    end
  end

  assign bus.FPUErr = fpuErr;
  assign bus.State  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. A reference model builds the
// expected per-cycle state trace of each instruction from the instruction
// class and FPU done delay, and the expected instruction length from the
// cycle-count rules; outputs come from a per-state table.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       irw;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       br;
    logic       aluop;
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       ressrc;
    logic       start;
  } outs_t;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount = 0;
  logic errExp = 1'b0;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.FPU_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Expected Moore outputs for each state number.
  function automatic outs_t expOut(input int st);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; o.irw = 1; o.npc = 1; end
      1:  begin o.srca = 2'b01; o.srcb = 2'b10; o.res = 2'b10; end
      2:  begin o.srca = 2'b00; o.srcb = 2'b01; end
      3:  begin o.adr = 1; end
      4:  begin o.res = 2'b01; o.regw = 1; end
      5:  begin o.adr = 1; o.memw = 1; end
      6:  begin o.aluop = 1; end
      7:  begin o.srcb = 2'b01; o.aluop = 1; end
      8:  begin o.regw = 1; end
      9:  begin o.srca = 2'b10; o.srcb = 2'b01; o.res = 2'b10; o.br = 1; end
      10: begin o.start = 1; o.ressrc = 1; end
      11: begin o.ressrc = 1; end
      12: begin o.res = 2'b11; o.ressrc = 1; o.regw = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.irw    = bus.IRWrite;
    o.npc    = bus.NextPC;
    o.regw   = bus.RegW;
    o.memw   = bus.MemW;
    o.br     = bus.Branch;
    o.aluop  = bus.ALUOp;
    o.adr    = bus.AdrSrc;
    o.srca   = bus.ALUSrcA;
    o.srcb   = bus.ALUSrcB;
    o.res    = bus.ResultSrc;
    o.ressrc = bus.ResSrc;
    o.start  = bus.FPUStart;
    return o;
  endfunction

  // Runs one instruction starting in FETCH. doneDelay is the number of
  // cycles between FPUStart and FPUDone; anything beyond TIMEOUT means the
  // FPU never answers. Outside the FPU states FPUDone is driven with noise.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                               input int doneDelay);
    int seq[$];
    int lenExp;
    int cyc;
    bit timedOut;
    timedOut = 0;
    bus.Op    = op;
    bus.Funct = funct;
    seq = {0, 1};
    case (op)
      2'b00: begin seq.push_back(funct[5] ? 7 : 6); seq.push_back(8); end
      2'b01: begin
        seq.push_back(2);
        if (funct[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b10: seq.push_back(9);
      default: begin
        seq.push_back(10);
        if (doneDelay <= TIMEOUT) begin
          repeat (doneDelay) seq.push_back(11);
          seq.push_back(12);
        end else begin
          repeat (TIMEOUT) seq.push_back(11);
          timedOut = 1;
        end
      end
    endcase
    case (op)
      2'b00:   lenExp = 4;
      2'b01:   lenExp = funct[0] ? 5 : 4;
      2'b10:   lenExp = 3;
      default: lenExp = timedOut ? 3 + TIMEOUT : 4 + doneDelay;
    endcase
    cyc = 0;
    while (1) begin
      if (cyc < seq.size()) begin
        checkOutput($sformatf("state op%0d c%0d", op, cyc), 32'(bus.State), seq[cyc]);
        checkOutput($sformatf("outputs op%0d c%0d", op, cyc), 32'(observed()), 32'(expOut(seq[cyc])));
        checkOutput($sformatf("fpuerr op%0d c%0d", op, cyc), 32'(bus.FPUErr), 32'(errExp));
        if (timedOut && cyc == seq.size() - 1) errExp = 1'b1;
        if (seq[cyc] == 10 || seq[cyc] == 11) bus.FPUDone = (cyc - 2 == doneDelay);
        else if (cyc == 0) bus.FPUDone = 1'b1;
        else bus.FPUDone = 1'($urandom_range(0, 1));
      end else begin
        checkOutput($sformatf("overrun op%0d", op), cyc, seq.size());
      end
      @(negedge clk);
      cyc++;
      if (bus.State == 4'd0 || cyc >= 40) break;
    end
    bus.FPUDone = 1'b0;
    checkOutput($sformatf("cycles op%0d", op), cyc, lenExp);
  endtask

  initial begin
    int cyc;
    int delay;
    reset       = 1'b0;
    bus.Op      = 2'b00;
    bus.Funct   = 6'b0;
    bus.FPUDone = 1'b0;

    // Held in reset: FETCH encoding, everything quiet.
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset state", 32'(bus.State), 0);
      checkOutput("reset outputs", 32'(observed()), 0);
      checkOutput("reset fpuerr", 32'(bus.FPUErr), 0);
    end
    reset = 1'b1;
    #1;

    // Directed instruction classes.
    applyStimulus(2'b00, 6'b100000, 0);
    applyStimulus(2'b00, 6'b000000, 0);
    applyStimulus(2'b01, 6'b000001, 0);
    applyStimulus(2'b01, 6'b000000, 0);
    applyStimulus(2'b10, 6'b000000, 0);
    applyStimulus(2'b11, 6'b000000, 0);
    applyStimulus(2'b11, 6'b000000, 3);
    applyStimulus(2'b11, 6'b000000, 1000);
    applyStimulus(2'b00, 6'b100001, 0);
    applyStimulus(2'b11, 6'b000000, TIMEOUT);

    // Reset asserted between edges while waiting on the FPU.
    bus.Op      = 2'b11;
    bus.Funct   = 6'b0;
    bus.FPUDone = 1'b0;
    cyc = 0;
    while (bus.State != 4'd11 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reach fpuwait", 32'(bus.State), 11);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset state", 32'(bus.State), 0);
    checkOutput("async reset outputs", 32'(observed()), 0);
    checkOutput("async reset fpuerr", 32'(bus.FPUErr), 0);
    errExp = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;

    // Randomised instruction stream.
    for (int i = 0; i < 40; i++) begin
      delay = $urandom_range(0, TIMEOUT + 3);
      applyStimulus(2'($urandom_range(0, 3)), 6'($urandom), delay);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle ARM-subset core with attached multi-cycle FPU. It sequences fetch, decode, memory, ALU, branch and FPU instructions over several cycles, driving the datapath mux selects and write strobes. Raw RegW/MemW/Branch strobes go to the condition logic, which gates them with CondEx. It also runs the FPU start/done handshake with a watchdog timeout.

## Interface
- FPU_TIMEOUT, 15: maximum cycles spent in FPUWAIT before abort; legal range 1 to 255.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 FPU.
- Funct  in  6  instr[25:20]. Funct[5] is I (immediate); Funct[0] is S/L (load for memory ops).
- FPUDone  in  1  FPU result valid, one-cycle pulse.
- IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc  out  1 each  datapath strobes and selects.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  mux selects.
- ResSrc  out  1  selects FPU flags and FlagW in the condition logic.
- FPUStart  out  1  one-cycle FPU launch pulse.
- FPUErr  out  1  sticky timeout flag.
- State  out  4  current state encoding, for debug.

## Operation
- Outputs are Moore, decoded from State. An output not listed for a state is 0.
- While reset=0: State=FETCH, the timeout counter is 0, FPUErr=0, and every output is forced to 0.
- State encodings, outputs and transitions:
  - FETCH=0: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1. Goes to DECODE.
  - DECODE=1: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by Op:
    - Op=00 with Funct[5]=1: EXECUTEI. Op=00 with Funct[5]=0: EXECUTER.
    - Op=01: MEMADR. Op=10: BRANCH. Op=11: FPUEXEC.
  - MEMADR=2: ALUSrcA=00, ALUSrcB=01. Goes to MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD=3: AdrSrc=1, ResultSrc=00. Goes to MEMWB.
  - MEMWB=4: ResultSrc=01, RegW=1. Goes to FETCH.
  - MEMWR=5: AdrSrc=1, ResultSrc=00, MemW=1. Goes to FETCH.
  - EXECUTER=6: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Goes to ALUWB.
  - EXECUTEI=7: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Goes to ALUWB.
  - ALUWB=8: ResultSrc=00, RegW=1. Goes to FETCH.
  - BRANCH=9: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1. Goes to FETCH.
  - FPUEXEC=10: FPUStart=1, ResSrc=1. Goes to FPUWB if FPUDone=1, else FPUWAIT.
  - FPUWAIT=11: ResSrc=1.
    - FPUDone=1: go to FPUWB.
    - Otherwise, counter==FPU_TIMEOUT-1: go to FETCH and set FPUErr.
    - Otherwise: counter increments and the FSM stays.
  - FPUWB=12: ResultSrc=11, ResSrc=1, RegW=1. Goes to FETCH.
- Encodings 13–15 are illegal and go to FETCH with all outputs 0.
- Timeout counter:
  - Width is $clog2(FPU_TIMEOUT+1).
  - Cleared to 0 in every cycle the FSM is not in FPUWAIT.
  - Never wraps.
- FPUDone sampled outside FPUEXEC and FPUWAIT is ignored. This includes a late done after a timeout.
- FPUDone arriving in the same cycle the counter reaches its limit wins: the FSM goes to FPUWB and FPUErr is not set.
- FPUErr is set on timeout and cleared only by reset.

## Timing
- Cycles per instruction:
  - Branch: 3 (FETCH, DECODE, BRANCH).
  - Store: 4.
  - Data-processing: 4.
  - Load: 5.
- FPU instruction:
  - FPUDone with FPUStart: 4 cycles.
  - FPUDone k cycles after FPUStart: 4+k cycles.
  - Timeout: 3+FPU_TIMEOUT cycles, with no RegW.
- FPUStart is high for exactly one cycle per FPU instruction.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronously). No RegW/MemW strobe completes.
- The first FETCH is the first rising edge after reset deasserts.

## Structure
- Shared package ctrl_pkg holds:
  - the state enum (4-bit, encodings above);
  - the ResultSrc codes: RES_ALUOUT=00, RES_DATA=01, RES_ALU=10, RES_FPU=11;
  - the ALUSrcA/ALUSrcB code constants.
- Sub-module fpu_timer holds the timeout counter.
  - Inputs: clk, reset, clr, inc.
  - Output: expired.
  - Parameterised by FPU_TIMEOUT.
- The FSM next-state logic and output decode stay in multicycle_ctrl.

## Test plan
- Reset held low for 3 cycles, then released → State=0 and all outputs 0 while low; IRWrite=1 and NextPC=1 on the first cycle after release.
- Op=00, Funct=6'b100000 → State sequence 0,1,7,8,0; RegW=1 only in state 8; ALUSrcB=01 in state 7.
- Op=01 with Funct[0]=1, then Op=01 with Funct[0]=0 → load sequence 0,1,2,3,4 with RegW in state 4; store sequence 0,1,2,5 with MemW in state 5.
- Op=11 with FPUDone driven on the FPUStart cycle, then a second FPU instruction with FPUDone 3 cycles after FPUStart → first takes 4 cycles, second 7 cycles; ResultSrc=11 and RegW=1 in state 12.
- Op=11, FPU_TIMEOUT=15, FPUDone never asserted → exactly 15 cycles in state 11, then FETCH with FPUErr=1 and no RegW; a FPUDone pulse on the next cycle is ignored.
- FPUDone on the counter-limit cycle, then reset pulsed low while in state 11 → first: FPUWB is taken and FPUErr stays 0; second: State=0 asynchronously and FPUErr=0.
